pingpong_scheduler: RTL and testbench

Sequences the two display frame buffers as a ping-pong pair. The host fills the back buffer through a valid/ready write handshake while the pixel pipeline reads the front buffer. The roles swap at vertical blank only when a complete frame has been written. The block drives the buffer enables, the address-counter controls and the frame-mux selects that the datapath currently takes from the display controller.

---
 rtl/display_pkg.sv | 13 +
 rtl/pingpong_scheduler_if.sv | 32 +++
 rtl/frame_word_counter.sv | 24 ++
 rtl/pingpong_scheduler.sv | 102 ++++++++++
 tb/tb_pingpong_scheduler.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and defaults for the ping-pong frame buffer scheduler.
package display_pkg;

  localparam int FRAME_WORDS_DEF = 1024;
  localparam int CNT_W_DEF       = 20;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } back_st_t;

endpackage

// File: rtl/pingpong_scheduler_if.sv
// Host write handshake, pixel-side strobes and buffer/mux controls of the scheduler.
interface pingpong_scheduler_if;

  logic       wr_valid;
  logic       wr_ready;
  logic       vb_start;
  logic       active_px;
  logic       WE0, WE1;
  logic       RE0, RE1;
  logic       IncAddr0, IncAddr1;
  logic       ResetAddr0, ResetAddr1;
  logic       SelBuf0, SelBuf1, SelBlank;
  logic       Buf0Empty, Buf1Empty;
  logic       front_idx;
  logic [7:0] repeat_cnt;
  logic       overrun;

  modport master (
    output wr_valid, vb_start, active_px,
    input  wr_ready, WE0, WE1, RE0, RE1, IncAddr0, IncAddr1,
           ResetAddr0, ResetAddr1, SelBuf0, SelBuf1, SelBlank,
           Buf0Empty, Buf1Empty, front_idx, repeat_cnt, overrun
  );

  modport slave (
    input  wr_valid, vb_start, active_px,
    output wr_ready, WE0, WE1, RE0, RE1, IncAddr0, IncAddr1,
           ResetAddr0, ResetAddr1, SelBuf0, SelBuf1, SelBlank,
           Buf0Empty, Buf1Empty, front_idx, repeat_cnt, overrun
  );

endinterface

// File: rtl/frame_word_counter.sv
// Clearable word counter with a flag raised when the count equals LIMIT.
module frame_word_counter #(
  parameter int CNT_W = 20,
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/pingpong_scheduler.sv
// Swaps two frame buffers at vertical blank once the back buffer holds a full frame.
module pingpong_scheduler
  import display_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pingpong_scheduler_if.slave  bus
);

  back_st_t   back_st, back_st_nxt;
  logic       front_idx, front_idx_nxt;
  logic       front_valid, front_valid_nxt;
  logic [7:0] repeat_cnt, repeat_cnt_nxt;
  logic       overrun, overrun_nxt;

  logic wr_last, rd_done;
  logic wr_xfer, rd_go, swap, rpt;
  logic wr_clr, rd_clr;

  // Write counter flags the last word of a frame; read counter flags exhaustion.
  frame_word_counter #(.CNT_W(CNT_W), .LIMIT(FRAME_WORDS - 1)) u_wr_cnt (
    .clk(clk), .clr(wr_clr), .inc(wr_xfer), .at_limit(wr_last)
  );

  frame_word_counter #(.CNT_W(CNT_W), .LIMIT(FRAME_WORDS)) u_rd_cnt (
    .clk(clk), .clr(rd_clr), .inc(rd_go), .at_limit(rd_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      back_st     <= EMPTY;
      front_idx   <= 1'b0;
      front_valid <= 1'b0;
      repeat_cnt  <= 8'd0;
      overrun     <= 1'b0;
    end else begin
      back_st     <= back_st_nxt;
      front_idx   <= front_idx_nxt;
      front_valid <= front_valid_nxt;
      repeat_cnt  <= repeat_cnt_nxt;
      overrun     <= overrun_nxt;
    end
  end

  always_comb begin
    back_st_nxt     = back_st;
    front_idx_nxt   = front_idx;
    front_valid_nxt = front_valid;
    repeat_cnt_nxt  = repeat_cnt;
    overrun_nxt     = overrun;

    bus.wr_ready = (back_st != FULL) && !reset;
    wr_xfer      = bus.wr_valid && bus.wr_ready;
    swap         = bus.vb_start && (back_st == FULL) && !reset;
    rpt          = bus.vb_start && (back_st != FULL) && front_valid && !reset;
    // vb_start takes priority over a coincident pixel request.
    rd_go        = bus.active_px && front_valid && !rd_done && !bus.vb_start && !reset;

    wr_clr = reset || swap || (wr_xfer && wr_last);
    rd_clr = reset || swap || rpt;

    if (swap) begin
      back_st_nxt     = EMPTY;
      front_idx_nxt   = ~front_idx;
      front_valid_nxt = 1'b1;
    end else if (wr_xfer) begin
      back_st_nxt = wr_last ? FULL : FILLING;
    end

    if (rpt && (repeat_cnt != 8'd255)) begin
      repeat_cnt_nxt = repeat_cnt + 8'd1;
    end

    if (bus.active_px && front_valid && rd_done && !bus.vb_start) begin
      overrun_nxt = 1'b1;
    end

    bus.WE0        = wr_xfer && front_idx;
    bus.WE1        = wr_xfer && !front_idx;
    bus.RE0        = rd_go && !front_idx;
    bus.RE1        = rd_go && front_idx;
    bus.IncAddr0   = bus.WE0 || bus.RE0;
    bus.IncAddr1   = bus.WE1 || bus.RE1;
    bus.SelBuf0    = bus.RE0;
    bus.SelBuf1    = bus.RE1;
    bus.SelBlank   = !rd_go;
    bus.ResetAddr0 = reset || swap || (rpt && !front_idx);
    bus.ResetAddr1 = reset || swap || (rpt && front_idx);

    // The back buffer is always the one not being displayed.
    bus.Buf0Empty  = reset || (front_idx ? (back_st == EMPTY) : !front_valid);
    bus.Buf1Empty  = reset || (front_idx ? !front_valid : (back_st == EMPTY));

    bus.front_idx  = front_idx;
    bus.repeat_cnt = repeat_cnt;
    bus.overrun    = overrun;
  end

endmodule

// File: tb/tb_pingpong_scheduler.sv
// Directed-vector bench for pingpong_scheduler with a four-word frame.
module tb_pingpong_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   we1_pulses;

  pingpong_scheduler_if bus ();

  pingpong_scheduler #(.FRAME_WORDS(4), .CNT_W(20)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one input vector at the falling edge and settle before checking.
  task automatic drive(input logic rs, input logic wv, input logic vb, input logic ap);
    @(negedge clk);
    reset         = rs;
    bus.wr_valid  = wv;
    bus.vb_start  = vb;
    bus.active_px = ap;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_ready"}, 32'(bus.wr_ready), 0);
    check_eq({tag, "_rst_addr0"}, 32'(bus.ResetAddr0), 1);
    check_eq({tag, "_rst_addr1"}, 32'(bus.ResetAddr1), 1);
    check_eq({tag, "_sel_blank"}, 32'(bus.SelBlank), 1);
    check_eq({tag, "_we"}, 32'({bus.WE0, bus.WE1}), 0);
    check_eq({tag, "_re_inc"}, 32'({bus.RE0, bus.RE1, bus.IncAddr0, bus.IncAddr1}), 0);
    check_eq({tag, "_empty"}, 32'({bus.Buf0Empty, bus.Buf1Empty}), 3);
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.vb_start  = 1'b0;
    bus.active_px = 1'b0;

    drive(1, 1, 0, 1);
    check_reset_outputs("reset");
    drive(1, 1, 0, 0);

    // Fill buffer 1 with a complete frame.
    we1_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      check_eq("fill_wr_ready", 32'(bus.wr_ready), 1);
      check_eq("fill_inc1", 32'(bus.IncAddr1), 1);
      check_eq("fill_we0", 32'(bus.WE0), 0);
      we1_pulses += int'(bus.WE1);
    end
    drive(0, 1, 0, 1);
    we1_pulses += int'(bus.WE1);
    check_eq("fill_we1_pulses", we1_pulses, 4);
    check_eq("full_wr_ready", 32'(bus.wr_ready), 0);
    check_eq("full_blank_no_front", 32'(bus.SelBlank), 1);
    check_eq("full_buf1_empty", 32'(bus.Buf1Empty), 0);
    check_eq("full_buf0_empty", 32'(bus.Buf0Empty), 1);

    drive(0, 0, 1, 0);
    check_eq("swap_rst_addr0", 32'(bus.ResetAddr0), 1);
    check_eq("swap_rst_addr1", 32'(bus.ResetAddr1), 1);
    drive(0, 0, 0, 0);
    check_eq("swap_front_idx", 32'(bus.front_idx), 1);
    check_eq("swap_buf1_empty", 32'(bus.Buf1Empty), 0);
    check_eq("swap_buf0_empty", 32'(bus.Buf0Empty), 1);
    check_eq("swap_wr_ready", 32'(bus.wr_ready), 1);

    // Read out the frame and run two words past its end.
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      check_eq("read_re1", 32'(bus.RE1), (i < 4) ? 1 : 0);
      check_eq("read_sel1", 32'(bus.SelBuf1), (i < 4) ? 1 : 0);
      check_eq("read_blank", 32'(bus.SelBlank), (i < 4) ? 0 : 1);
      if (i == 4) check_eq("overrun_not_yet", 32'(bus.overrun), 0);
    end
    drive(0, 0, 0, 0);
    check_eq("overrun_set", 32'(bus.overrun), 1);

    // Repeat with a half-filled back buffer.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0);
      check_eq("part_we0", 32'(bus.WE0), 1);
    end
    drive(0, 0, 1, 0);
    check_eq("rpt_rst_addr1", 32'(bus.ResetAddr1), 1);
    check_eq("rpt_rst_addr0", 32'(bus.ResetAddr0), 0);
    drive(0, 0, 0, 1);
    check_eq("rpt_front_idx", 32'(bus.front_idx), 1);
    check_eq("rpt_count", 32'(bus.repeat_cnt), 1);
    check_eq("rpt_reread", 32'(bus.RE1), 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0);
      check_eq("rest_we0", 32'(bus.WE0), 1);
    end
    drive(0, 0, 0, 0);
    check_eq("rest_full", 32'(bus.wr_ready), 0);
    check_eq("rest_buf0_empty", 32'(bus.Buf0Empty), 0);

    // Swap to buffer 0, then land the final write of buffer 1 on vb_start.
    drive(0, 0, 1, 0);
    check_eq("swap2_rst_addr", 32'({bus.ResetAddr0, bus.ResetAddr1}), 3);
    drive(0, 0, 0, 0);
    check_eq("swap2_front_idx", 32'(bus.front_idx), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      check_eq("late_we1", 32'(bus.WE1), 1);
    end
    drive(0, 1, 1, 0);
    check_eq("coinc_we1", 32'(bus.WE1), 1);
    check_eq("coinc_rst_addr1", 32'(bus.ResetAddr1), 0);
    check_eq("coinc_rst_addr0", 32'(bus.ResetAddr0), 1);
    drive(0, 0, 0, 0);
    check_eq("coinc_no_swap", 32'(bus.front_idx), 0);
    check_eq("coinc_full", 32'(bus.wr_ready), 0);
    check_eq("coinc_rpt_count", 32'(bus.repeat_cnt), 2);
    drive(0, 0, 1, 1);
    check_eq("vb_wins_blank", 32'(bus.SelBlank), 1);
    check_eq("vb_wins_re", 32'({bus.RE0, bus.RE1}), 0);
    drive(0, 0, 0, 0);
    check_eq("coinc_swap_next", 32'(bus.front_idx), 1);

    // Saturate the repeat counter.
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 1, 0);
      if (i == 253) check_eq("rpt_at_sat", 32'(bus.repeat_cnt), 255);
    end
    drive(0, 0, 0, 0);
    check_eq("rpt_saturated", 32'(bus.repeat_cnt), 255);

    // Reset in the middle of a back-buffer fill.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0);
      check_eq("pre_rst_we0", 32'(bus.WE0), 1);
    end
    drive(1, 1, 0, 1);
    check_reset_outputs("mid_reset");
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 1);
    check_eq("post_rst_wr_ready", 32'(bus.wr_ready), 1);
    check_eq("post_rst_we1", 32'(bus.WE1), 1);
    check_eq("post_rst_front_idx", 32'(bus.front_idx), 0);
    check_eq("post_rst_rpt", 32'(bus.repeat_cnt), 0);
    check_eq("post_rst_overrun", 32'(bus.overrun), 0);
    check_eq("post_rst_blank", 32'(bus.SelBlank), 1);
    check_eq("post_rst_empty", 32'({bus.Buf0Empty, bus.Buf1Empty}), 3);
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
